// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst read scheduler over NUM_CH synchronous FIFOs.
// One channel is granted at a time. Reads are issued only while the 4-entry
// output buffer has room for every word already requested. Returned words
// are queued oldest-first and tagged with their source channel.
module fifo_rd_sched #(
   parameter int NUM_CH    = 4,
   parameter int FIFO_DWTH = 8,
   parameter int BURST_LEN = 4,
   parameter int CH_W      = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           fifo_empty,
   input  logic [NUM_CH-1:0]           fifo_valid,
   input  logic [NUM_CH*FIFO_DWTH-1:0] fifo_dout,
   output logic [NUM_CH-1:0]           fifo_rden,
   output logic [FIFO_DWTH-1:0]        out_data,
   output logic [CH_W-1:0]             out_ch,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam int              IW        = $clog2(BURST_LEN + 1);
   localparam logic [IW-1:0]   BURST_MAX = IW'(BURST_LEN);
   localparam logic [1:0]      ST_IDLE   = 2'd0;
   localparam logic [1:0]      ST_BURST  = 2'd1;
   localparam logic [1:0]      ST_DRAIN  = 2'd2;

   logic [1:0]           state_r;
   logic [CH_W-1:0]      gnt_r;
   logic [CH_W-1:0]      last_r;
   logic [IW-1:0]        issued_r;
   logic [2:0]           inflight_r;
   logic [2:0]           bcnt_r;
   logic [1:0]           wr_ptr_r;
   logic [1:0]           rd_ptr_r;
   logic [FIFO_DWTH-1:0] buf_data_r [4];
   logic [CH_W-1:0]      buf_ch_r   [4];

   logic [FIFO_DWTH-1:0] dout_word_s [NUM_CH];
   logic [CH_W:0]        pick_s;
   logic                 credit_ok_s;
   logic                 issue_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 burst_end_s;
   logic                 drain_done_s;
   logic [NUM_CH-1:0]    rden_s;

   // First non-empty channel after 'last', wrapping; MSB flags that one exists.
   // Walking k downward lets the nearest candidate overwrite farther ones.
   function automatic logic [CH_W:0] rr_pick(input logic [CH_W-1:0] last,
                                             input logic [NUM_CH-1:0] empty);
      logic [CH_W:0]   pick;
      logic [CH_W-1:0] idx;
      pick = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = CH_W'((int'(last) + k) % NUM_CH);
         if (!empty[idx]) begin
            pick = {1'b1, idx};
         end
      end
      return pick;
   endfunction

   // Split the concatenated FIFO data bus into per-channel words.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         dout_word_s[c] = fifo_dout[c*FIFO_DWTH +: FIFO_DWTH];
      end
   end

   // Issue, return and handshake decisions for this cycle.
   always_comb begin
      pick_s       = rr_pick(last_r, fifo_empty);
      credit_ok_s  = ({1'b0, bcnt_r} + {1'b0, inflight_r}) < 4'd4;
      if (state_r == ST_BURST) begin
         issue_s = !fifo_empty[gnt_r] && (issued_r < BURST_MAX) && credit_ok_s;
      end else begin
         issue_s = 1'b0;
      end
      push_s       = fifo_valid[gnt_r] && (inflight_r != 3'd0);
      pop_s        = (bcnt_r != 3'd0) && out_ready;
      burst_end_s  = (issue_s && ((issued_r + IW'(1)) == BURST_MAX)) || fifo_empty[gnt_r];
      drain_done_s = (inflight_r == 3'd0) || ((inflight_r == 3'd1) && push_s);
      rden_s       = '0;
      if (issue_s) begin
         rden_s[gnt_r] = 1'b1;
      end else begin
         rden_s = '0;
      end
   end

   // Grant state machine and read accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         gnt_r      <= '0;
         last_r     <= CH_W'(NUM_CH - 1);
         issued_r   <= '0;
         inflight_r <= 3'd0;
      end else begin
         inflight_r <= inflight_r + 3'(issue_s) - 3'(push_s);
         case (state_r)
            ST_IDLE: begin
               if (pick_s[CH_W]) begin
                  gnt_r    <= pick_s[CH_W-1:0];
                  issued_r <= '0;
                  state_r  <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (issue_s) begin
                  issued_r <= issued_r + IW'(1);
               end
               if (burst_end_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  last_r  <= gnt_r;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Output buffer: oldest-first, push on return, pop on accepted handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         bcnt_r   <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            buf_data_r[i] <= '0;
            buf_ch_r[i]   <= '0;
         end
      end else begin
         if (push_s) begin
            buf_data_r[wr_ptr_r] <= dout_word_s[gnt_r];
            buf_ch_r[wr_ptr_r]   <= gnt_r;
            wr_ptr_r             <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         bcnt_r <= bcnt_r + 3'(push_s) - 3'(pop_s);
      end
   end

   assign fifo_rden = rden_s;
   assign out_data  = buf_data_r[rd_ptr_r];
   assign out_ch    = buf_ch_r[rd_ptr_r];
   assign out_valid = (bcnt_r != 3'd0);
   assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: behavioural FIFO models, per-channel scoreboard
// filled at load time and drained as words leave the scheduler.
module tb_fifo_rd_sched;
   localparam int NUM_CH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  fifo_empty = 4'hF;
   logic [3:0]  fifo_valid = 4'h0;
   logic [31:0] fifo_dout;
   logic [3:0]  fifo_rden;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   logic [7:0]  mdout [NUM_CH] = '{8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0]  fq [NUM_CH][$];
   logic [3:0]  ld_en;
   int          ld_cnt;
   logic [7:0]  ld_seed;
   logic        flush;

   logic [7:0]  exp_ch [NUM_CH][$];
   int          total = 0;
   int          bad = 0;
   int          gnt_log[$];
   int          bsz_log[$];
   int          rd_cnt[NUM_CH];
   bit          in_burst;

   fifo_rd_sched #(.NUM_CH(4), .FIFO_DWTH(8), .BURST_LEN(4), .CH_W(2)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
      .fifo_dout(fifo_dout), .fifo_rden(fifo_rden), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

   always #5 clk = ~clk;

   assign fifo_dout = {mdout[3], mdout[2], mdout[1], mdout[0]};

   // FIFO models: one-cycle read latency, contents survive rst, flush empties them.
   always @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         fifo_valid[c] <= 1'b0;
         if (flush) begin
            fq[c].delete();
         end else begin
            if (!rst && fifo_rden[c] && fq[c].size() != 0) begin
               mdout[c]      <= fq[c].pop_front();
               fifo_valid[c] <= 1'b1;
            end
            if (ld_en[c]) begin
               for (int k = 0; k < ld_cnt; k++) fq[c].push_back(ld_seed + 8'(c*32 + k));
            end
         end
         fifo_empty[c] <= (fq[c].size() == 0);
      end
   end

   // Sample what the next edge will see, score it, then advance half a cycle past it.
   task automatic tick();
      logic [7:0] e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            total++;
            if (exp_ch[out_ch].size() == 0) begin
               bad++;
               $display("FAIL scoreboard: got ch%0d data %0h, required no word", out_ch, out_data);
            end else begin
               e = exp_ch[out_ch].pop_front();
               if (out_data !== e) begin
                  bad++;
                  $display("FAIL scoreboard ch%0d: got %0h required %0h", out_ch, out_data, e);
               end
            end
         end
         if (fifo_rden != 4'b0) begin
            total++;
            if (!$onehot(fifo_rden) || (fifo_rden & fifo_empty) != 4'b0) begin
               bad++;
               $display("FAIL rden_legal: rden=%b empty=%b required one-hot on non-empty", fifo_rden, fifo_empty);
            end
            for (int c = 0; c < NUM_CH; c++) begin
               if (fifo_rden[c]) begin
                  rd_cnt[c]++;
                  if (!in_burst) begin
                     gnt_log.push_back(c);
                     bsz_log.push_back(0);
                     in_burst = 1'b1;
                  end
                  bsz_log[bsz_log.size()-1]++;
               end
            end
         end
         if (!busy) in_burst = 1'b0;
      end else begin
         in_burst = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [3:0] mask, input int n, input logic [7:0] seed);
      ld_en = mask; ld_cnt = n; ld_seed = seed;
      for (int c = 0; c < NUM_CH; c++)
         if (mask[c]) for (int k = 0; k < n; k++) exp_ch[c].push_back(seed + 8'(c*32 + k));
      tick();
      ld_en = 4'b0;
   endtask

   task automatic clear_logs();
      gnt_log.delete(); bsz_log.delete();
      for (int c = 0; c < NUM_CH; c++) rd_cnt[c] = 0;
   endtask

   task automatic wait_idle(input int maxc);
      int  n;
      bit  done;
      n = 0; done = 1'b0;
      while (!done && n < maxc) begin
         tick(); n++;
         done = (busy === 1'b0) && (out_valid === 1'b0) && (fifo_empty === 4'hF) && (fifo_valid === 4'h0);
      end
      total++;
      if (!done) begin bad++; $display("FAIL idle_timeout: busy=%b out_valid=%b after %0d cycles, required idle", busy, out_valid, n); end
   endtask

   task automatic test_reset();
      int exp_sz;
      rst = 1'b1; out_ready = 1'b0; ld_en = 4'b0; flush = 1'b0; ld_cnt = 0; ld_seed = 8'h0;
      clear_logs();
      tick();
      load(4'hF, 2, 8'h10);
      for (int i = 0; i < 3; i++) begin
         tick(); total++;
         if ({fifo_rden, out_valid, out_data, out_ch, busy} !== 16'h0) begin
            bad++; $display("FAIL reset_outputs: rden=%b valid=%b data=%h ch=%0d busy=%b required all 0", fifo_rden, out_valid, out_data, out_ch, busy);
         end
      end
      rst = 1'b0; total++;
      if (fifo_rden !== 4'b0000) begin bad++; $display("FAIL rden_first_cycle: got %b required 0000", fifo_rden); end
      tick(); total++;
      if (fifo_rden !== 4'b0001) begin bad++; $display("FAIL rden_second_cycle: got %b required 0001", fifo_rden); end
      out_ready = 1'b1;
      wait_idle(200);
      total++;
      if (gnt_log.size() != 4) begin bad++; $display("FAIL reset_grants: got %0d grants required 4", gnt_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++;
         if (gnt_log[i] != i || bsz_log[i] != 2) begin bad++; $display("FAIL reset_grant%0d: got ch%0d x%0d required ch%0d x2", i, gnt_log[i], bsz_log[i], i); end
      end
      exp_sz = 0; for (int c = 0; c < NUM_CH; c++) exp_sz += exp_ch[c].size();
      total++;
      if (exp_sz != 0) begin bad++; $display("FAIL reset_lost: %0d words missing required 0", exp_sz); end
   endtask

   task automatic test_single_channel();
      clear_logs(); out_ready = 1'b1;
      load(4'b0100, 3, 8'hA0);
      wait_idle(100);
      total++;
      if (rd_cnt[2] != 3) begin bad++; $display("FAIL single_reads: got %0d required 3", rd_cnt[2]); end
      total++;
      if (gnt_log.size() != 1 || gnt_log[0] != 2) begin bad++; $display("FAIL single_grant: got %0d grants required one grant of ch2", gnt_log.size()); end
      total++;
      if (exp_ch[2].size() != 0) begin bad++; $display("FAIL single_lost: %0d words missing required 0", exp_ch[2].size()); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b required 0", busy); end
   endtask

   task automatic test_round_robin();
      int eg[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      int eb[12] = '{4, 4, 4, 4, 4, 4, 4, 4, 2, 2, 2, 2};
      int exp_sz;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      clear_logs(); out_ready = 1'b1;
      load(4'hF, 10, 8'h00);
      wait_idle(400);
      total++;
      if (gnt_log.size() != 12) begin bad++; $display("FAIL rr_grants: got %0d grants required 12", gnt_log.size()); end
      else for (int i = 0; i < 12; i++) begin
         total++;
         if (gnt_log[i] != eg[i] || bsz_log[i] != eb[i]) begin bad++; $display("FAIL rr_grant%0d: got ch%0d x%0d required ch%0d x%0d", i, gnt_log[i], bsz_log[i], eg[i], eb[i]); end
      end
      exp_sz = 0; for (int c = 0; c < NUM_CH; c++) exp_sz += exp_ch[c].size();
      total++;
      if (exp_sz != 0) begin bad++; $display("FAIL rr_lost: %0d words missing required 0", exp_sz); end
   endtask

   task automatic test_backpressure();
      logic [7:0] hold_d;
      bit         have;
      have = 1'b0; hold_d = 8'h00;
      clear_logs(); out_ready = 1'b0;
      load(4'b0001, 8, 8'h40);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid === 1'b1) begin
            if (!have) begin hold_d = out_data; have = 1'b1; end
            else begin
               total++;
               if (out_data !== hold_d || out_ch !== 2'd0) begin bad++; $display("FAIL bp_stable: got ch%0d %h required ch0 %h", out_ch, out_data, hold_d); end
            end
         end
      end
      total++;
      if (rd_cnt[0] != 4) begin bad++; $display("FAIL bp_reads: got %0d required 4", rd_cnt[0]); end
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h40) begin bad++; $display("FAIL bp_head: valid=%b data=%h required 1 40", out_valid, out_data); end
      out_ready = 1'b1;
      wait_idle(200);
      total++;
      if (rd_cnt[0] != 8 || exp_ch[0].size() != 0) begin bad++; $display("FAIL bp_release: reads=%0d missing=%0d required 8 and 0", rd_cnt[0], exp_ch[0].size()); end
   endtask

   task automatic test_fairness();
      int eg[3] = '{1, 0, 1};
      int eb[3] = '{4, 3, 2};
      clear_logs(); out_ready = 1'b1;
      load(4'b0010, 6, 8'h60);
      for (int i = 0; i < 30 && rd_cnt[1] == 0; i++) tick();
      total++;
      if (rd_cnt[1] == 0) begin bad++; $display("FAIL fair_start: got no ch1 read required one within 30 cycles"); end
      load(4'b0001, 3, 8'h80);
      wait_idle(200);
      total++;
      if (gnt_log.size() != 3) begin bad++; $display("FAIL fair_grants: got %0d grants required 3", gnt_log.size()); end
      else for (int i = 0; i < 3; i++) begin
         total++;
         if (gnt_log[i] != eg[i] || bsz_log[i] != eb[i]) begin bad++; $display("FAIL fair_grant%0d: got ch%0d x%0d required ch%0d x%0d", i, gnt_log[i], bsz_log[i], eg[i], eb[i]); end
      end
      total++;
      if (exp_ch[0].size() + exp_ch[1].size() != 0) begin bad++; $display("FAIL fair_lost: words missing, required none"); end
   endtask

   task automatic test_reset_mid();
      int eg[2] = '{0, 2};
      clear_logs(); out_ready = 1'b1;
      load(4'b0100, 8, 8'hA0);
      for (int i = 0; i < 30 && rd_cnt[2] < 2; i++) tick();
      total++;
      if (rd_cnt[2] < 2) begin bad++; $display("FAIL mid_start: got %0d reads required 2", rd_cnt[2]); end
      rst = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int c = 0; c < NUM_CH; c++) exp_ch[c].delete();
      total++;
      if ({fifo_rden, out_valid, out_data, out_ch, busy} !== 16'h0) begin
         bad++; $display("FAIL mid_reset_outputs: rden=%b valid=%b data=%h ch=%0d busy=%b required all 0", fifo_rden, out_valid, out_data, out_ch, busy);
      end
      tick(); rst = 1'b0;
      clear_logs();
      load(4'b0101, 2, 8'hC0);
      wait_idle(200);
      total++;
      if (gnt_log.size() != 2) begin bad++; $display("FAIL mid_grants: got %0d grants required 2", gnt_log.size()); end
      else for (int i = 0; i < 2; i++) begin
         total++;
         if (gnt_log[i] != eg[i] || bsz_log[i] != 2) begin bad++; $display("FAIL mid_grant%0d: got ch%0d x%0d required ch%0d x2", i, gnt_log[i], bsz_log[i], eg[i]); end
      end
      total++;
      if (exp_ch[0].size() + exp_ch[2].size() != 0) begin bad++; $display("FAIL mid_lost: words missing, required none"); end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
